// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, load/store and memory-macro buses around mem_arbiter.
// The arbiter connects through the slave modport; its environment uses master.
interface mem_arbiter_if #(
  parameter int ADDR_W = 8
);
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;

  logic              mb_req;
  logic              mb_we;
  logic [3:0]        mb_wstrb;
  logic [31:0]       mb_addr;
  logic [31:0]       mb_wdata;
  logic              mb_gnt;
  logic              mb_rvalid;
  logic [31:0]       mb_rdata;
  logic              mb_err;

  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  mb_req, mb_we, mb_wstrb, mb_addr, mb_wdata,
    output mb_gnt, mb_rvalid, mb_rdata, mb_err,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output mb_req, mb_we, mb_wstrb, mb_addr, mb_wdata,
    input  mb_gnt, mb_rvalid, mb_rdata, mb_err,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: load/store has priority, a starvation counter
// forces fetch through, read data is returned one cycle later to its owner.
module mem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_MB   = 2'd2
  } owner_t;

  owner_t     owner, owner_nxt;
  logic [3:0] starve_cnt, starve_nxt;
  logic       mb_err_p1, mb_err_nxt;

  logic       forced;
  logic       if_gnt_c;
  logic       mb_gnt_c;
  logic       mb_aligned;
  logic       mb_issue;

  // Fetch ignores its byte offset; only the word-address bits reach memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.if_addr[1:0], bus.if_addr[31:ADDR_W+2],
                              bus.mb_addr[31:ADDR_W+2]};

  // Stage p0: combinational grant and memory drive
  always_comb begin
    forced   = bus.if_req && (starve_cnt == STARVE_LIM);
    if_gnt_c = 1'b0;
    mb_gnt_c = 1'b0;
    if (!rst) begin
      if (forced)          if_gnt_c = 1'b1;
      else if (bus.mb_req) mb_gnt_c = 1'b1;
      else                 if_gnt_c = bus.if_req;
    end
  end

  assign mb_aligned = (bus.mb_addr[1:0] == 2'b00);
  assign mb_issue   = mb_gnt_c && mb_aligned;

  assign bus.if_gnt    = if_gnt_c;
  assign bus.mb_gnt    = mb_gnt_c;
  assign bus.mem_en    = if_gnt_c || mb_issue;
  assign bus.mem_we    = (mb_issue && bus.mb_we) ? bus.mb_wstrb : 4'b0000;
  assign bus.mem_addr  = if_gnt_c ? bus.if_addr[ADDR_W+1:2] : bus.mb_addr[ADDR_W+1:2];
  assign bus.mem_wdata = bus.mb_wdata;

  always_comb begin
    owner_nxt  = OWN_NONE;
    mb_err_nxt = mb_gnt_c && !mb_aligned;
    starve_nxt = 4'd0;
    if (if_gnt_c)
      owner_nxt = OWN_IF;
    else if (mb_issue && !bus.mb_we)
      owner_nxt = OWN_MB;
    if (bus.if_req && !if_gnt_c)
      starve_nxt = (starve_cnt == STARVE_LIM) ? starve_cnt : starve_cnt + 4'd1;
  end

  // Stage p1: response ownership and starvation state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner      <= OWN_NONE;
      starve_cnt <= 4'd0;
      mb_err_p1  <= 1'b0;
    end else begin
      owner      <= owner_nxt;
      starve_cnt <= starve_nxt;
      mb_err_p1  <= mb_err_nxt;
    end
  end

  assign bus.if_rvalid = (owner == OWN_IF);
  assign bus.mb_rvalid = (owner == OWN_MB);
  assign bus.mb_err    = mb_err_p1;
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.mb_rdata  = bus.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a shadow-memory
// reference model of grants, responses and errors.
module tb_mem_arbiter;
  localparam int ADDR_W     = 8;
  localparam int STARVE_MAX = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] merge(input logic [31:0] old_w,
                                        input logic [31:0] wd,
                                        input logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Memory macro with a preload port used only while the arbiter is in reset
  logic [31:0] mem [256];
  logic        poke_en   = 1'b0;
  logic [7:0]  poke_addr = 8'd0;
  logic [31:0] poke_data = 32'd0;

  always @(posedge clk) begin
    if (poke_en)
      mem[poke_addr] <= poke_data;
    else if (bus.mem_en) begin
      if (bus.mem_we == 4'b0000) bus.mem_rdata <= mem[bus.mem_addr];
      else mem[bus.mem_addr] <= merge(mem[bus.mem_addr], bus.mem_wdata, bus.mem_we);
    end
  end

  // Reference model state
  logic [31:0] shadow [256];
  int          m_pend   = 0;
  bit          m_err    = 1'b0;
  logic [31:0] m_data   = 32'd0;
  int          m_denied = 0;
  int          m_wait   = 0;
  bit          g_if = 1'b0, g_mb = 1'b0;

  logic        s_if_gnt, s_mb_gnt, s_mem_en, s_if_rvalid, s_mb_rvalid, s_mb_err;
  logic [31:0] s_if_rdata, s_mb_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: inputs are already applied; sample late in the cycle,
  // compare against the model, advance the model, return just after the edge.
  task automatic step();
    logic       e_if, e_mb, e_en, aligned;
    logic [3:0] e_we;
    logic [7:0] e_addr;
    #3;
    if (rst) begin
      m_pend = 0; m_err = 1'b0; m_denied = 0;
    end
    s_if_gnt    = bus.if_gnt;    s_mb_gnt    = bus.mb_gnt;
    s_mem_en    = bus.mem_en;    s_mb_err    = bus.mb_err;
    s_if_rvalid = bus.if_rvalid; s_mb_rvalid = bus.mb_rvalid;
    s_if_rdata  = bus.if_rdata;  s_mb_rdata  = bus.mb_rdata;

    check("if_rvalid", 32'(s_if_rvalid), 32'(m_pend == 1));
    check("mb_rvalid", 32'(s_mb_rvalid), 32'(m_pend == 2));
    check("mb_err", 32'(s_mb_err), 32'(m_err));
    if (m_pend == 1) check("if_rdata", s_if_rdata, m_data);
    if (m_pend == 2) check("mb_rdata", s_mb_rdata, m_data);
    check("starve_cnt", 32'(dut.starve_cnt), 32'(m_denied));

    e_if = 1'b0;
    e_mb = 1'b0;
    if (!rst) begin
      if (bus.if_req && m_denied == STARVE_MAX) e_if = 1'b1;
      else if (bus.mb_req)                      e_mb = 1'b1;
      else                                      e_if = bus.if_req;
    end
    aligned = (bus.mb_addr[1:0] == 2'b00);
    e_en    = e_if || (e_mb && aligned);
    e_we    = (e_mb && aligned && bus.mb_we) ? bus.mb_wstrb : 4'b0000;
    e_addr  = e_if ? bus.if_addr[9:2] : bus.mb_addr[9:2];

    check("if_gnt", 32'(s_if_gnt), 32'(e_if));
    check("mb_gnt", 32'(s_mb_gnt), 32'(e_mb));
    check("mem_en", 32'(s_mem_en), 32'(e_en));
    check("mem_we", 32'(bus.mem_we), 32'(e_we));
    if (e_en) check("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
    if (e_we != 4'b0000) check("mem_wdata", bus.mem_wdata, bus.mb_wdata);

    if (bus.if_req && !rst) begin
      if (s_if_gnt) begin
        check("if_wait_bound", 32'(m_wait <= STARVE_MAX), 32'd1);
        m_wait = 0;
      end else m_wait++;
    end else m_wait = 0;

    m_pend = 0;
    m_err  = 1'b0;
    if (e_if) begin
      m_pend = 1; m_data = shadow[e_addr];
    end else if (e_mb && aligned && !bus.mb_we) begin
      m_pend = 2; m_data = shadow[e_addr];
    end
    if (e_mb && !aligned) m_err = 1'b1;
    if (e_mb && aligned && bus.mb_we)
      shadow[e_addr] = merge(shadow[e_addr], bus.mb_wdata, bus.mb_wstrb);
    if (bus.if_req && !e_if && !rst)
      m_denied = (m_denied < STARVE_MAX) ? m_denied + 1 : STARVE_MAX;
    else
      m_denied = 0;

    g_if = s_if_gnt;
    g_mb = s_mb_gnt;
    @(posedge clk);
    #1;
  endtask

  task automatic set_mb(input logic req, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wd);
    bus.mb_req = req; bus.mb_we = we; bus.mb_wstrb = be;
    bus.mb_addr = addr; bus.mb_wdata = wd;
  endtask

  initial begin
    logic [31:0] r;
    rst = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = 32'd0;
    set_mb(1'b0, 1'b0, 4'b0, 32'd0, 32'd0);
    @(posedge clk);
    #1;

    // Reset state with both requests raised: everything held quiet
    bus.if_req = 1'b1;
    set_mb(1'b1, 1'b1, 4'hF, 32'h0, 32'h5555_5555);
    step();
    check("rst_grants", 32'({s_if_gnt, s_mb_gnt, s_mem_en}), 32'd0);
    step();
    bus.if_req = 1'b0;
    set_mb(1'b0, 1'b0, 4'b0, 32'd0, 32'd0);

    // Preload memory and shadow while still in reset
    poke_en = 1'b1;
    for (int i = 0; i < 256 + 2; i++) begin
      if (i < 256) begin poke_addr = 8'(i); poke_data = $urandom; end
      else if (i == 256) begin poke_addr = 8'd4; poke_data = 32'hDEAD_BEEF; end
      else begin poke_addr = 8'd8; poke_data = 32'hAAAA_AAAA; end
      shadow[poke_addr] = poke_data;
      @(posedge clk);
      #1;
    end
    poke_en = 1'b0;
    rst = 1'b0;

    // Lone fetch
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    step();
    check("lone_gnt", 32'(s_if_gnt), 32'd1);
    check("lone_addr", 32'(bus.mem_addr), 32'd4);
    bus.if_req = 1'b0;
    step();
    check("lone_rvalid", 32'(s_if_rvalid), 32'd1);
    check("lone_rdata", s_if_rdata, 32'hDEAD_BEEF);

    // Store then load of the same word
    set_mb(1'b1, 1'b1, 4'b0011, 32'h20, 32'h1234_5678);
    step();
    set_mb(1'b1, 1'b0, 4'b0000, 32'h20, 32'h0);
    step();
    check("st_no_rvalid", 32'(s_mb_rvalid), 32'd0);
    set_mb(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
    step();
    check("ld_rvalid", 32'(s_mb_rvalid), 32'd1);
    check("ld_rdata", s_mb_rdata, 32'hAAAA_5678);

    // Misaligned load followed by a fetch
    set_mb(1'b1, 1'b0, 4'b0000, 32'h22, 32'h0);
    step();
    check("mis_gnt", 32'(s_mb_gnt), 32'd1);
    check("mis_mem_en", 32'(s_mem_en), 32'd0);
    set_mb(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
    bus.if_req = 1'b1; bus.if_addr = 32'h40;
    step();
    check("mis_err", 32'(s_mb_err), 32'd1);
    check("mis_rvalid", 32'(s_mb_rvalid), 32'd0);
    check("mis_if_gnt", 32'(s_if_gnt), 32'd1);
    bus.if_req = 1'b0;
    step();
    check("mis_if_rvalid", 32'(s_if_rvalid), 32'd1);
    check("mis_err_pulse", 32'(s_mb_err), 32'd0);

    // Contention: MB, MB, MB, IF repeating
    bus.if_req = 1'b1; bus.if_addr = 32'h80;
    set_mb(1'b1, 1'b0, 4'b0000, 32'h84, 32'h0);
    for (int i = 0; i < 8; i++) begin
      step();
      check("cont_if_gnt", 32'(s_if_gnt), 32'(i % 4 == 3));
      check("cont_mb_gnt", 32'(s_mb_gnt), 32'(i % 4 != 3));
    end
    bus.if_req = 1'b0;
    set_mb(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
    step();

    // Reset one cycle after a fetch grant
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    step();
    bus.if_req = 1'b0;
    rst = 1'b1;
    step();
    check("rst_rvalid", 32'(s_if_rvalid), 32'd0);
    rst = 1'b0;
    step();
    check("rst_rel_rvalid", 32'(s_if_rvalid), 32'd0);
    check("rst_starve", 32'(dut.starve_cnt), 32'd0);

    // Idle
    for (int i = 0; i < 5; i++) begin
      step();
      check("idle_mem_en", 32'(s_mem_en), 32'd0);
    end

    // Randomized traffic with held-until-granted requesters
    g_if = 1'b0; g_mb = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (!bus.if_req || g_if) begin
        bus.if_req = ($urandom_range(0, 3) != 0);
        r = $urandom;
        bus.if_addr = r;
      end
      if (!bus.mb_req || g_mb) begin
        r = $urandom;
        if ($urandom_range(0, 7) != 0) r[1:0] = 2'b00;
        set_mb($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)), r, $urandom);
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
